math_computer_arbiter: RTL and testbench

MATH_COMPUTER_ARBITER -- requirements
Module: math_computer_arbiter

---
 rtl/math_computer_arb_pkg.sv | 14 +
 rtl/math_computer_itf.sv | 25 ++
 rtl/math_arb_tag_fifo.sv | 55 +++++
 rtl/math_computer_arbiter.sv | 106 ++++++++++
 tb/tb_math_computer_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/math_computer_arb_pkg.sv
// Shared types for the math computer arbiter.
//   req_id_t    : requester id (0 or 1), also the tag stored per in-flight op
//   arb_state_t : arbiter FSM states (ARB = free to pick, HOLD = winner latched)
// Also provides a default for the `DATASIZE operand/result width macro.
`ifndef DATASIZE
`define DATASIZE 32
`endif

package math_computer_arb_pkg;
  typedef logic req_id_t;
  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_t;
  // Pointer value after reset, so requester 0 wins the first tie.
  localparam req_id_t LAST_GNT_RST = 1'b1;
endpackage

// File: rtl/math_computer_itf.sv
// Valid/ready interfaces to and from the shared math computer.
//   math_computer_input_itf  : operands a, b, c + valid/ready (3*`DATASIZE + 2)
//   math_computer_output_itf : result + valid/ready (`DATASIZE + 2)
// master drives data/valid, slave drives ready.
`ifndef DATASIZE
`define DATASIZE 32
`endif

interface math_computer_input_itf;
  logic [`DATASIZE-1:0] a;
  logic [`DATASIZE-1:0] b;
  logic [`DATASIZE-1:0] c;
  logic                 valid;
  logic                 ready;
  modport master (output a, b, c, valid, input ready);
  modport slave  (input a, b, c, valid, output ready);
endinterface

interface math_computer_output_itf;
  logic [`DATASIZE-1:0] result;
  logic                 valid;
  logic                 ready;
  modport master (output result, valid, input ready);
  modport slave  (input result, valid, output ready);
endinterface

// File: rtl/math_arb_tag_fifo.sv
// Tag FIFO: remembers which requester owns each operation in flight, in
// issue order, so results can be routed back.
//   clk, rst    : clock, async active-high reset (FIFO emptied)
//   push, din   : enqueue a requester id (ignored while full, even with pop)
//   pop, dout   : dequeue; dout is the head id (valid when !empty)
//   full, empty : occupancy flags
// FIFODEPTH must be a power of two, so pointers wrap by natural overflow.
module math_arb_tag_fifo
  import math_computer_arb_pkg::*;
#(
  parameter int FIFODEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(FIFODEPTH);
  localparam logic [AW:0] FULL_CNT = FIFODEPTH[AW:0];

  req_id_t       mem [FIFODEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < FIFODEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/math_computer_arbiter.sv
// Two-requester arbiter in front of one shared math computer.
//   clk, rst          : clock, async active-high reset
//   req0_in, req1_in  : operation requests (slave)
//   comp_in           : operation issued to the math computer (master)
//   comp_out          : results from the math computer (slave)
//   res0_out,res1_out : results routed back to each requester (master)
//   orphan_err        : sticky, a result arrived with no tag outstanding
// Build option: define MATH_ARB_ROUND_ROBIN_EN for round-robin on ties;
// otherwise requester 0 has fixed priority.
module math_computer_arbiter
  import math_computer_arb_pkg::*;
#(
  parameter int FIFODEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  math_computer_input_itf.slave   req0_in,
  math_computer_input_itf.slave   req1_in,
  math_computer_input_itf.master  comp_in,
  math_computer_output_itf.slave  comp_out,
  math_computer_output_itf.master res0_out,
  math_computer_output_itf.master res1_out,
  output logic                    orphan_err
);
  arb_state_t state;
  req_id_t    held, win, head;
  logic       has_win, cin_valid, issue, cout_ready;
  logic       fifo_full, fifo_empty;
`ifdef MATH_ARB_ROUND_ROBIN_EN
  req_id_t    last_gnt;
`endif

  // Winner select. HOLD pins the latched winner until it issues; in ARB a
  // new winner is only picked when there is room to tag it.
  always_comb begin
    win     = 1'b0;
    has_win = 1'b0;
    if (state == HOLD) begin
      win     = held;
      has_win = 1'b1;
    end else if (!fifo_full) begin
      has_win = req0_in.valid | req1_in.valid;
      if (req0_in.valid && req1_in.valid)
`ifdef MATH_ARB_ROUND_ROBIN_EN
        win = ~last_gnt;
`else
        win = 1'b0;
`endif
      else
        win = req1_in.valid & ~req0_in.valid;
    end
  end

  // Issue path; everything forced to 0 while rst is high.
  assign cin_valid     = has_win & ~rst;
  assign issue         = cin_valid & comp_in.ready;
  assign comp_in.valid = cin_valid;
  assign comp_in.a     = !cin_valid ? '0 : (win ? req1_in.a : req0_in.a);
  assign comp_in.b     = !cin_valid ? '0 : (win ? req1_in.b : req0_in.b);
  assign comp_in.c     = !cin_valid ? '0 : (win ? req1_in.c : req0_in.c);
  assign req0_in.ready = issue & (win == 1'b0);
  assign req1_in.ready = issue & (win == 1'b1);

  // Return path: head tag steers the result, zero-cycle latency.
  assign cout_ready     = ~rst & ~fifo_empty & (head ? res1_out.ready : res0_out.ready);
  assign comp_out.ready = cout_ready;
  assign res0_out.valid = ~rst & comp_out.valid & ~fifo_empty & (head == 1'b0);
  assign res1_out.valid = ~rst & comp_out.valid & ~fifo_empty & (head == 1'b1);
  assign res0_out.result = rst ? '0 : comp_out.result;
  assign res1_out.result = rst ? '0 : comp_out.result;

  math_arb_tag_fifo #(.FIFODEPTH(FIFODEPTH)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (comp_out.valid & cout_ready),
    .din   (win),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      held       <= 1'b0;
      orphan_err <= 1'b0;
`ifdef MATH_ARB_ROUND_ROBIN_EN
      last_gnt   <= LAST_GNT_RST;
`endif
    end else begin
      case (state)
        ARB: if (has_win && !comp_in.ready) begin
          state <= HOLD;
          held  <= win;
        end
        HOLD: if (comp_in.ready) state <= ARB;
        default: state <= ARB;
      endcase
`ifdef MATH_ARB_ROUND_ROBIN_EN
      if (issue) last_gnt <= win;
`endif
      if (comp_out.valid && fifo_empty) orphan_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_math_computer_arbiter.sv
// Directed self-checking bench for math_computer_arbiter (FIFODEPTH = 4).
module tb_math_computer_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic orphan_err;
  int   checks = 0;
  int   errors = 0;

  math_computer_input_itf  req0_if ();
  math_computer_input_itf  req1_if ();
  math_computer_input_itf  comp_in_if ();
  math_computer_output_itf comp_out_if ();
  math_computer_output_itf res0_if ();
  math_computer_output_itf res1_if ();

  math_computer_arbiter #(.FIFODEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_in    (req0_if),
    .req1_in    (req1_if),
    .comp_in    (comp_in_if),
    .comp_out   (comp_out_if),
    .res0_out   (res0_if),
    .res1_out   (res1_if),
    .orphan_err (orphan_err)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, outputs are checked at posedge+2.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_if.valid = 0; req0_if.a = 0; req0_if.b = 0; req0_if.c = 0;
    req1_if.valid = 0; req1_if.a = 0; req1_if.b = 0; req1_if.c = 0;
    comp_in_if.ready = 0;
    comp_out_if.valid = 0; comp_out_if.result = 0;
    res0_if.ready = 0; res1_if.ready = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    req0_if.valid = 1; req0_if.a = 5; comp_in_if.ready = 1;
    comp_out_if.valid = 1; comp_out_if.result = 9;
    res0_if.ready = 1; res1_if.ready = 1;
    #1;
    checks++; if (comp_in_if.valid !== 1'b0) begin errors++; $display("FAIL rst_cin_valid: got %b exp 0", comp_in_if.valid); end
    checks++; if (req0_if.ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready: got %b exp 0", req0_if.ready); end
    checks++; if (comp_in_if.a !== 32'd0) begin errors++; $display("FAIL rst_cin_a: got %0d exp 0", comp_in_if.a); end
    checks++; if (comp_out_if.ready !== 1'b0) begin errors++; $display("FAIL rst_cout_ready: got %b exp 0", comp_out_if.ready); end
    checks++; if (res0_if.valid !== 1'b0) begin errors++; $display("FAIL rst_res0_valid: got %b exp 0", res0_if.valid); end
    checks++; if (res0_if.result !== 32'd0) begin errors++; $display("FAIL rst_res0_result: got %0d exp 0", res0_if.result); end
    tick();
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL rst_orphan: got %b exp 0", orphan_err); end
  endtask

  // Both requesters always valid, computer always ready; results returned
  // one cycle later so the tag FIFO never fills.
  task automatic test_arbitration;
    logic [3:0] wseq;
    logic [1:0] got, exp;
`ifdef MATH_ARB_ROUND_ROBIN_EN
    wseq = 4'b1010;
`else
    wseq = 4'b0000;
`endif
    do_reset();
    req0_if.valid = 1; req0_if.a = 11;
    req1_if.valid = 1; req1_if.a = 22;
    comp_in_if.ready = 1; res0_if.ready = 1; res1_if.ready = 1;
    for (int k = 0; k < 4; k++) begin
      comp_out_if.valid = (k > 0);
      comp_out_if.result = 32'(100 + k);
      #1;
      got = {req1_if.ready, req0_if.ready};
      exp = wseq[k] ? 2'b10 : 2'b01;
      checks++; if (got !== exp) begin errors++; $display("FAIL arb_grant k=%0d: got %b exp %b", k, got, exp); end
      checks++; if (comp_in_if.a !== (wseq[k] ? 32'd22 : 32'd11)) begin errors++; $display("FAIL arb_cin_a k=%0d: got %0d", k, comp_in_if.a); end
      if (k > 0) begin
        got = {res1_if.valid, res0_if.valid};
        exp = wseq[k-1] ? 2'b10 : 2'b01;
        checks++; if (got !== exp) begin errors++; $display("FAIL arb_route k=%0d: got %b exp %b", k, got, exp); end
        checks++; if (res0_if.result !== 32'(100 + k) || res1_if.result !== 32'(100 + k)) begin
          errors++; $display("FAIL arb_bcast k=%0d: got %0d/%0d exp %0d", k, res0_if.result, res1_if.result, 100 + k); end
      end
      tick();
    end
    req0_if.valid = 0; req1_if.valid = 0;
    comp_out_if.valid = 1; comp_out_if.result = 104;
    #1;
    got = {res1_if.valid, res0_if.valid};
    exp = wseq[3] ? 2'b10 : 2'b01;
    checks++; if (got !== exp) begin errors++; $display("FAIL arb_drain: got %b exp %b", got, exp); end
    tick();
    comp_out_if.valid = 0;
    #1;
    checks++; if (comp_out_if.ready !== 1'b0) begin errors++; $display("FAIL arb_empty_ready: got %b exp 0", comp_out_if.ready); end
  endtask

  task automatic test_hold;
    do_reset();
    req1_if.valid = 1; req1_if.a = 3; req1_if.b = 4; req1_if.c = 5;
    req0_if.a = 7; req0_if.b = 8; req0_if.c = 9;
    comp_in_if.ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (comp_in_if.valid !== 1'b1 || comp_in_if.a !== 32'd3 || comp_in_if.b !== 32'd4 || comp_in_if.c !== 32'd5) begin
        errors++; $display("FAIL hold_data k=%0d: got v=%b %0d/%0d/%0d exp v=1 3/4/5", k, comp_in_if.valid, comp_in_if.a, comp_in_if.b, comp_in_if.c); end
      checks++; if ({req1_if.ready, req0_if.ready} !== 2'b00) begin errors++; $display("FAIL hold_ready k=%0d: got %b exp 00", k, {req1_if.ready, req0_if.ready}); end
      tick();
      req0_if.valid = 1;
    end
    comp_in_if.ready = 1;
    #1;
    checks++; if ({req1_if.ready, req0_if.ready} !== 2'b10 || comp_in_if.a !== 32'd3) begin
      errors++; $display("FAIL hold_issue: got %b a=%0d exp 10 a=3", {req1_if.ready, req0_if.ready}, comp_in_if.a); end
    tick();
    req1_if.valid = 0;
    #1;
    checks++; if ({req1_if.ready, req0_if.ready} !== 2'b01 || comp_in_if.a !== 32'd7) begin
      errors++; $display("FAIL hold_next: got %b a=%0d exp 01 a=7", {req1_if.ready, req0_if.ready}, comp_in_if.a); end
    tick();
    req0_if.valid = 0;
  endtask

  task automatic test_fifo_full;
    do_reset();
    req0_if.valid = 1; comp_in_if.ready = 1; res0_if.ready = 1; res1_if.ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req0_if.ready !== 1'b1) begin errors++; $display("FAIL full_fill k=%0d: got %b exp 1", k, req0_if.ready); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (req0_if.ready !== 1'b0 || comp_in_if.valid !== 1'b0) begin
        errors++; $display("FAIL full_block k=%0d: got r=%b v=%b exp 0/0", k, req0_if.ready, comp_in_if.valid); end
      tick();
    end
    comp_out_if.valid = 1; comp_out_if.result = 55;
    #1;
    checks++; if (comp_out_if.ready !== 1'b1 || res0_if.valid !== 1'b1) begin
      errors++; $display("FAIL full_pop: got cr=%b r0v=%b exp 1/1", comp_out_if.ready, res0_if.valid); end
    checks++; if (req0_if.ready !== 1'b0) begin errors++; $display("FAIL full_nopush: got %b exp 0", req0_if.ready); end
    tick();
    comp_out_if.valid = 0;
    #1;
    checks++; if (req0_if.ready !== 1'b1) begin errors++; $display("FAIL full_refill: got %b exp 1", req0_if.ready); end
    tick();
    #1;
    checks++; if (req0_if.ready !== 1'b0) begin errors++; $display("FAIL full_again: got %b exp 0", req0_if.ready); end
    req0_if.valid = 0;
  endtask

  task automatic test_routing;
    do_reset();
    comp_in_if.ready = 1;
    req0_if.valid = 1; #1;
    checks++; if (req0_if.ready !== 1'b1) begin errors++; $display("FAIL route_iss0: got %b exp 1", req0_if.ready); end
    tick();
    req0_if.valid = 0; req1_if.valid = 1; #1;
    checks++; if (req1_if.ready !== 1'b1) begin errors++; $display("FAIL route_iss1: got %b exp 1", req1_if.ready); end
    tick();
    req1_if.valid = 0; req0_if.valid = 1; #1;
    checks++; if (req0_if.ready !== 1'b1) begin errors++; $display("FAIL route_iss2: got %b exp 1", req0_if.ready); end
    tick();
    req0_if.valid = 0;
    res0_if.ready = 1; res1_if.ready = 1;
    comp_out_if.valid = 1; comp_out_if.result = 10; #1;
    checks++; if ({res1_if.valid, res0_if.valid, comp_out_if.ready} !== 3'b011 || res0_if.result !== 32'd10) begin
      errors++; $display("FAIL route_r10: got v=%b%b cr=%b res=%0d exp 01 1 10", res1_if.valid, res0_if.valid, comp_out_if.ready, res0_if.result); end
    tick();
    comp_out_if.result = 20; res1_if.ready = 0; #1;
    checks++; if ({res1_if.valid, res0_if.valid, comp_out_if.ready} !== 3'b100) begin
      errors++; $display("FAIL route_stall: got v=%b%b cr=%b exp 10 0", res1_if.valid, res0_if.valid, comp_out_if.ready); end
    tick();
    res1_if.ready = 1; #1;
    checks++; if (comp_out_if.ready !== 1'b1 || res1_if.result !== 32'd20 || res1_if.valid !== 1'b1) begin
      errors++; $display("FAIL route_r20: got cr=%b v=%b res=%0d exp 1 1 20", comp_out_if.ready, res1_if.valid, res1_if.result); end
    tick();
    comp_out_if.result = 30; #1;
    checks++; if ({res1_if.valid, res0_if.valid} !== 2'b01 || res0_if.result !== 32'd30) begin
      errors++; $display("FAIL route_r30: got v=%b%b res=%0d exp 01 30", res1_if.valid, res0_if.valid, res0_if.result); end
    tick();
    comp_out_if.valid = 0; #1;
    checks++; if (comp_out_if.ready !== 1'b0 || orphan_err !== 1'b0) begin
      errors++; $display("FAIL route_done: got cr=%b orphan=%b exp 0/0", comp_out_if.ready, orphan_err); end
  endtask

  task automatic test_orphan;
    do_reset();
    res0_if.ready = 1; res1_if.ready = 1;
    comp_out_if.valid = 1; comp_out_if.result = 77; #1;
    checks++; if (comp_out_if.ready !== 1'b0 || res0_if.valid !== 1'b0) begin
      errors++; $display("FAIL orphan_ready: got cr=%b r0v=%b exp 0/0", comp_out_if.ready, res0_if.valid); end
    tick();
    comp_out_if.valid = 0;
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b exp 1", orphan_err); end
    tick(); tick();
    checks++; if (orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b exp 1", orphan_err); end
    rst = 1; #1;
    checks++; if (orphan_err !== 1'b0) begin errors++; $display("FAIL orphan_clear: got %b exp 0", orphan_err); end
    tick();
    rst = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    comp_in_if.ready = 1; res0_if.ready = 1; res1_if.ready = 1;
    req0_if.valid = 1; tick();
    req0_if.valid = 0; req1_if.valid = 1; tick();
    req1_if.valid = 0; req0_if.valid = 1;
    comp_out_if.valid = 1; comp_out_if.result = 42; #1;
    checks++; if (res0_if.valid !== 1'b1 || comp_in_if.valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got r0v=%b cv=%b exp 1/1", res0_if.valid, comp_in_if.valid); end
    rst = 1; #1;
    checks++; if ({comp_in_if.valid, req0_if.ready, comp_out_if.ready, res0_if.valid, res1_if.valid} !== 5'b0) begin
      errors++; $display("FAIL mid_rst: got %b exp 00000", {comp_in_if.valid, req0_if.ready, comp_out_if.ready, res0_if.valid, res1_if.valid}); end
    checks++; if (orphan_err !== 1'b0 || res0_if.result !== 32'd0) begin
      errors++; $display("FAIL mid_rst_data: got orphan=%b res=%0d exp 0/0", orphan_err, res0_if.result); end
    idle_inputs();
    tick();
    rst = 0;
    res0_if.ready = 1; res1_if.ready = 1;
    comp_out_if.valid = 1; comp_out_if.result = 42; #1;
    checks++; if (comp_out_if.ready !== 1'b0 || res0_if.valid !== 1'b0 || res1_if.valid !== 1'b0) begin
      errors++; $display("FAIL mid_empty: got cr=%b v=%b%b exp 0 00", comp_out_if.ready, res1_if.valid, res0_if.valid); end
    comp_out_if.valid = 0;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_hold();
    test_fifo_full();
    test_routing();
    test_orphan();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
